// File: rtl/preempt_handler.sv
// Preemption consumer: on a timer preempt, waits for an instruction boundary, saves the PC,
// picks the next runnable process round-robin and reloads PC. Optional macro: PREEMPT_STATS_EN.
module preempt_handler #(
  parameter int  PID_WIDTH = 2,
  parameter int  PC_WIDTH  = 8,
  localparam int NUM_PROC  = 2 ** PID_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 preemptSignal,
  input  logic                 instrDone,
  input  logic [PC_WIDTH-1:0]  pcIn,
  input  logic [NUM_PROC-1:0]  procActive,
`ifdef PREEMPT_STATS_EN
  output logic [15:0]          switchCount,
`endif
  output logic                 countSignal,
  output logic                 holdFetch,
  output logic                 irResetSel,
  output logic                 pcLoad,
  output logic [PC_WIDTH-1:0]  pcOut,
  output logic [PID_WIDTH-1:0] curProc
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    PENDING = 3'd1,
    SAVE    = 3'd2,
    SELECT  = 3'd3,
    LOAD    = 3'd4
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [PID_WIDTH-1:0] cur_proc;
  logic [PID_WIDTH-1:0] next_proc;
  logic [PC_WIDTH-1:0]  saved_pc;
  logic [PC_WIDTH-1:0]  ctx [NUM_PROC];
  logic                 run_count;

  // Round-robin pick starting after cur; cur itself is the last candidate and the fallback.
  function automatic logic [PID_WIDTH-1:0] pick_next(
    input logic [PID_WIDTH-1:0] cur,
    input logic [NUM_PROC-1:0]  mask
  );
    logic [PID_WIDTH-1:0] idx;
    logic                 found;
    pick_next = cur;
    found     = 1'b0;
    for (int i = 1; i <= NUM_PROC; i++) begin
      idx = cur + PID_WIDTH'(i);
      if (!found && mask[idx]) begin
        pick_next = idx;
        found     = 1'b1;
      end
    end
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    run_count  = 1'b0;
    holdFetch  = 1'b0;
    irResetSel = 1'b0;
    pcLoad     = 1'b0;
    pcOut      = '0;
    case (state)
      RUN: begin
        run_count = 1'b1;
        if (preemptSignal) begin
          state_next = instrDone ? SAVE : PENDING;
        end
      end
      PENDING: begin
        if (instrDone) begin
          state_next = SAVE;
        end
      end
      SAVE: begin
        holdFetch  = 1'b1;
        irResetSel = 1'b1;
        state_next = SELECT;
      end
      SELECT: begin
        holdFetch  = 1'b1;
        irResetSel = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        holdFetch  = 1'b1;
        irResetSel = 1'b1;
        pcLoad     = 1'b1;
        pcOut      = ctx[next_proc];
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Timer enable drops the moment reset rises, not at the next edge.
  assign countSignal = run_count & ~reset;
  assign curProc     = cur_proc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_proc  <= '0;
      next_proc <= '0;
      saved_pc  <= '0;
      for (int i = 0; i < NUM_PROC; i++) begin
        ctx[i] <= '0;
      end
    end else begin
      case (state)
        RUN: begin
          if (preemptSignal && instrDone) begin
            saved_pc <= pcIn;
          end
        end
        PENDING: begin
          if (instrDone) begin
            saved_pc <= pcIn;
          end
        end
        SAVE: begin
          ctx[cur_proc] <= saved_pc;
        end
        SELECT: begin
          next_proc <= pick_next(cur_proc, procActive);
        end
        LOAD: begin
          cur_proc <= next_proc;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PREEMPT_STATS_EN
  // Counts only real switches; self-switches leave it alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      switchCount <= '0;
    end else if (state == LOAD && next_proc != cur_proc && switchCount != 16'hFFFF) begin
      switchCount <= switchCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_preempt_handler.sv
// Self-checking bench for preempt_handler against a round-robin context-switch model.
// Build with PREEMPT_STATS_EN defined to also cover the switch counter.
module tb_preempt_handler;

  logic       clock;
  logic       reset;
  logic       preemptSignal;
  logic       instrDone;
  logic [7:0] pcIn;
  logic [3:0] procActive;
  logic       countSignal;
  logic       holdFetch;
  logic       irResetSel;
  logic       pcLoad;
  logic [7:0] pcOut;
  logic [1:0] curProc;
`ifdef PREEMPT_STATS_EN
  logic [15:0] switchCount;
`endif

  int total;
  int bad;

  int         m_cur;
  logic [7:0] m_ctx [4];
  int         m_switches;

  preempt_handler #(.PID_WIDTH(2), .PC_WIDTH(8)) dut (
    .clock(clock),
    .reset(reset),
    .preemptSignal(preemptSignal),
    .instrDone(instrDone),
    .pcIn(pcIn),
    .procActive(procActive),
`ifdef PREEMPT_STATS_EN
    .switchCount(switchCount),
`endif
    .countSignal(countSignal),
    .holdFetch(holdFetch),
    .irResetSel(irResetSel),
    .pcLoad(pcLoad),
    .pcOut(pcOut),
    .curProc(curProc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void model_reset();
    m_cur      = 0;
    m_switches = 0;
    for (int i = 0; i < 4; i++) m_ctx[i] = 8'h00;
  endfunction

  // Save pc for the running process, return the PC the reload should deliver.
  function automatic logic [7:0] model_switch(input logic [7:0] pc, input logic [3:0] mask);
    int nxt;
    m_ctx[m_cur] = pc;
    nxt = m_cur;
    for (int k = 1; k <= 4; k++) begin
      if (mask[(m_cur + k) % 4]) begin
        nxt = (m_cur + k) % 4;
        break;
      end
    end
    if (nxt != m_cur) m_switches++;
    m_cur = nxt;
    return m_ctx[nxt];
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    preemptSignal = 1'b0;
    instrDone = 1'b0;
    pcIn = 8'h00;
    procActive = 4'h0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
  endtask

  // Drives one preempt and collects what the DUT did; pend = cycles spent waiting for instrDone.
  task automatic run_switch(input logic [7:0] pc, input int pend, input logic [3:0] mask,
                            output int load_at, output int stalls, output logic [7:0] pc_seen,
                            output int pend_bad, output int timed_out);
    pend_bad = 0;
    load_at = 0;
    stalls = 0;
    pc_seen = 8'h00;
    timed_out = 1;
    @(negedge clock);
    preemptSignal = 1'b1;
    instrDone = (pend == 0);
    pcIn = (pend == 0) ? pc : 8'($urandom);
    procActive = 4'($urandom);
    for (int k = 1; k <= pend; k++) begin
      @(negedge clock);
      if (countSignal !== 1'b0 || holdFetch !== 1'b0) pend_bad++;
      preemptSignal = 1'($urandom_range(0, 1));
      instrDone = (k == pend);
      pcIn = (k == pend) ? pc : 8'($urandom);
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      instrDone = 1'b0;
      pcIn = 8'($urandom);
      if (holdFetch === 1'b1 && irResetSel === 1'b1) stalls++;
      if (pcLoad === 1'b1 && load_at == 0) begin
        load_at = c;
        pc_seen = pcOut;
      end
      if (countSignal === 1'b1 && holdFetch === 1'b0) begin
        preemptSignal = 1'b0;
        timed_out = 0;
        break;
      end
      preemptSignal = 1'($urandom_range(0, 1));
      procActive = (c <= 2) ? mask : 4'($urandom);
    end
  endtask

  // Runs one switch through the model and compares every observation.
  task automatic switch_and_check(input string name, input logic [7:0] pc, input int pend,
                                  input logic [3:0] mask);
    int         load_at, stalls, pend_bad, timed_out;
    logic [7:0] pc_seen, exp_pc;
    exp_pc = model_switch(pc, mask);
    run_switch(pc, pend, mask, load_at, stalls, pc_seen, pend_bad, timed_out);
    total++;
    if (timed_out !== 0) begin
      bad++;
      $display("[TB] FAIL %s timeout: RUN not reached within 8 cycles", name);
    end
    total++;
    if (load_at !== 3) begin
      bad++;
      $display("[TB] FAIL %s load_latency: got %0d expected 3", name, load_at);
    end
    total++;
    if (stalls !== 3) begin
      bad++;
      $display("[TB] FAIL %s stall_cycles: got %0d expected 3", name, stalls);
    end
    total++;
    if (pc_seen !== exp_pc) begin
      bad++;
      $display("[TB] FAIL %s pcOut: got %0h expected %0h", name, pc_seen, exp_pc);
    end
    total++;
    if (curProc !== 2'(m_cur)) begin
      bad++;
      $display("[TB] FAIL %s curProc: got %0d expected %0d", name, curProc, m_cur);
    end
    if (pend > 0) begin
      total++;
      if (pend_bad !== 0) begin
        bad++;
        $display("[TB] FAIL %s pending_outputs: got %0d bad cycles expected 0", name, pend_bad);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    preemptSignal = 1'b0;
    instrDone = 1'b0;
    pcIn = 8'h00;
    procActive = 4'hF;
    @(negedge clock);
    total++;
    if (countSignal !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_count: got %0b expected 0", countSignal);
    end
    total++;
    if (holdFetch !== 1'b0 || irResetSel !== 1'b0 || pcLoad !== 1'b0 || pcOut !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %0b%0b%0b/%0h expected 000/0", holdFetch, irResetSel, pcLoad, pcOut);
    end
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    total++;
    if (countSignal !== 1'b1) begin
      bad++;
      $display("[TB] FAIL release_count: got %0b expected 1", countSignal);
    end
    total++;
    if (curProc !== 2'd0 || pcOut !== 8'h00 || holdFetch !== 1'b0) begin
      bad++;
      $display("[TB] FAIL release_state: got %0d/%0h/%0b expected 0/0/0", curProc, pcOut, holdFetch);
    end
  endtask

  task automatic test_basic_switch();
    switch_and_check("basic_0to1", 8'h2A, 0, 4'b1111);
    switch_and_check("basic_back_to_0", 8'h55, 0, 4'b0001);
  endtask

  task automatic test_pending();
    switch_and_check("pending_5", 8'h17, 5, 4'b1111);
  endtask

  task automatic test_round_robin();
    switch_and_check("rr_to_0", 8'h31, 0, 4'b0001);
    switch_and_check("rr_0to3", 8'h42, 0, 4'b1001);
    switch_and_check("rr_3to0_wrap", 8'h63, 0, 4'b1001);
    switch_and_check("rr_self_empty", 8'h7C, 2, 4'b0000);
  endtask

  task automatic test_reset_mid_switch();
    @(negedge clock);
    preemptSignal = 1'b1;
    instrDone = 1'b1;
    pcIn = 8'h99;
    procActive = 4'b1111;
    @(negedge clock);
    preemptSignal = 1'b0;
    instrDone = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    total++;
    if (countSignal !== 1'b0 || holdFetch !== 1'b0 || irResetSel !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_ctrl: got %0b%0b%0b expected 000", countSignal, holdFetch, irResetSel);
    end
    total++;
    if (pcLoad !== 1'b0 || pcOut !== 8'h00 || curProc !== 2'd0) begin
      bad++;
      $display("[TB] FAIL midreset_data: got %0b/%0h/%0d expected 0/0/0", pcLoad, pcOut, curProc);
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    total++;
    if (countSignal !== 1'b1 || curProc !== 2'd0) begin
      bad++;
      $display("[TB] FAIL midreset_release: got %0b/%0d expected 1/0", countSignal, curProc);
    end
    for (int i = 0; i < 4; i++) begin
      switch_and_check("post_reset_walk", 8'($urandom), 0, 4'b1111);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      switch_and_check("random", 8'($urandom), int'($urandom_range(0, 3)), 4'($urandom));
    end
  endtask

`ifdef PREEMPT_STATS_EN
  task automatic test_stats();
    apply_reset();
    switch_and_check("stats_1", 8'h11, 0, 4'b0010);
    switch_and_check("stats_2", 8'h22, 0, 4'b0100);
    switch_and_check("stats_self", 8'h33, 0, 4'b0100);
    switch_and_check("stats_3", 8'h44, 1, 4'b1000);
    total++;
    if (switchCount !== 16'(m_switches) || m_switches != 3) begin
      bad++;
      $display("[TB] FAIL switch_count: got %0d expected 3", switchCount);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    model_reset();
    test_reset();
    test_basic_switch();
    test_pending();
    test_round_robin();
    test_reset_mid_switch();
    test_random();
`ifdef PREEMPT_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
